// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NR_CH-to-1 registered multiplexer with valid/ready handshake.
// A round-robin (or fixed-priority) arbiter picks the source channel and the
// winning payload is captured in a single-entry output slot.
module rr_arb_mux #(
  parameter int NR_CH      = 4,
  parameter int DATA_LEN   = 32,
  parameter int FIXED_PRIO = 0,
  localparam int CH_W      = $clog2(NR_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NR_CH-1:0]          in_valid,
  input  logic [NR_CH*DATA_LEN-1:0] in_data,
  output logic [NR_CH-1:0]          in_ready,
  output logic                      out_valid,
  output logic [DATA_LEN-1:0]       out_data,
  output logic [CH_W-1:0]           out_ch,
  input  logic                      out_ready
);

  // One extra bit so base + offset never overflows before the wrap.
  localparam int IW = CH_W + 1;

  logic [CH_W-1:0]  last_gnt;
  logic [CH_W-1:0]  search_base;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_found;
  logic [NR_CH-1:0] grant;
  logic             load_en;

  // Slot may accept new data when empty or being drained this cycle.
  always_comb begin
    load_en = !out_valid || out_ready;
  end

  // Search begins just after the previous winner, or pinned before channel 0
  // in fixed-priority mode so channel 0 is examined first.
  always_comb begin
    search_base = (FIXED_PRIO != 0) ? CH_W'(NR_CH - 1) : last_gnt;
  end

  // Arbiter: first valid channel at offsets 1..NR_CH from the search base.
  always_comb begin
    logic [IW-1:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    grant     = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= NR_CH; k++) begin
      idx = {1'b0, search_base} + IW'(k);
      if (idx >= IW'(NR_CH)) begin
        idx = idx - IW'(NR_CH);
      end
      if (!gnt_found && in_valid[idx[CH_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[CH_W-1:0];
      end
    end
    if (gnt_found) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  // Accept strobe: only the granted channel, only when the slot can load,
  // and never while reset is held.
  always_comb begin
    in_ready = (load_en && rst_n) ? grant : '0;
  end

  // Output slot and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last_gnt  <= CH_W'(NR_CH - 1);
    end else if (load_en) begin
      if (gnt_found) begin
        out_valid <= 1'b1;
        out_data  <= in_data[gnt_idx*DATA_LEN +: DATA_LEN];
        out_ch    <= gnt_idx;
        last_gnt  <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: drives a round-robin and a fixed-priority instance with the
// same inputs and compares both against a slot-level reference model.
module tb_rr_arb_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic         out_ready;

  logic [3:0]   rdy0, rdy1;
  logic         ov0, ov1;
  logic [31:0]  od0, od1;
  logic [1:0]   och0, och1;

  int pass_cnt = 0;
  int total    = 0;

  // Reference model state, index 0 = round-robin, 1 = fixed priority.
  logic        m_v    [2];
  logic [31:0] m_d    [2];
  logic [1:0]  m_ch   [2];
  int          m_last [2];

  always #5 clk = ~clk;

  rr_arb_mux #(.NR_CH(4), .DATA_LEN(32), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_ch(och0),
    .out_ready(out_ready)
  );

  rr_arb_mux #(.NR_CH(4), .DATA_LEN(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_ch(och1),
    .out_ready(out_ready)
  );

  function automatic logic [3:0] o_rdy(int n); return (n == 1) ? rdy1 : rdy0; endfunction
  function automatic logic       o_v  (int n); return (n == 1) ? ov1  : ov0;  endfunction
  function automatic logic [31:0] o_d (int n); return (n == 1) ? od1  : od0;  endfunction
  function automatic logic [1:0] o_ch (int n); return (n == 1) ? och1 : och0; endfunction

  function automatic void model_reset();
    for (int n = 0; n < 2; n++) begin
      m_v[n] = 1'b0; m_d[n] = '0; m_ch[n] = '0; m_last[n] = 3;
    end
  endfunction

  // Channel the model would accept this cycle, or -1.
  function automatic int exp_grant(int n);
    int s;
    if (!rst_n) return -1;
    if (m_v[n] && !out_ready) return -1;
    s = (n == 1) ? 0 : (m_last[n] + 1) % 4;
    for (int k = 0; k < 4; k++)
      if (((in_valid >> ((s + k) % 4)) & 4'b1) != 4'b0) return (s + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(int n);
    int g = exp_grant(n);
    return (g < 0) ? 4'b0 : (4'(1) << g);
  endfunction

  // Advance one clock, applying the model's view of the edge.
  task automatic tick();
    int g [2];
    logic drain [2];
    for (int n = 0; n < 2; n++) begin
      g[n] = exp_grant(n);
      drain[n] = !m_v[n] || out_ready;
    end
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if (!rst_n) begin
        m_v[n] = 1'b0; m_d[n] = '0; m_ch[n] = '0; m_last[n] = 3;
      end else if (g[n] >= 0) begin
        m_v[n] = 1'b1; m_ch[n] = 2'(g[n]);
        m_d[n] = 32'(in_data >> (32 * g[n])); m_last[n] = g[n];
      end else if (drain[n]) begin
        m_v[n] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++) in_data[32*i +: 32] = {8'(8'hC0 + i), 24'($urandom)};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b1; in_data = '0;
    model_reset();
    #1;
    for (int c = 0; c < 10; c++) begin
      set_data();
      tick();
      for (int n = 0; n < 2; n++) begin
        total++;
        if ({o_v(n), o_rdy(n), o_d(n), o_ch(n)} !== {1'b0, 4'b0, 32'h0, 2'b0})
          $display("FAIL reset_state inst%0d cyc%0d: got v=%b rdy=%b d=%h ch=%0d want 0", n, c, o_v(n), o_rdy(n), o_d(n), o_ch(n));
        else pass_cnt++;
      end
    end
    in_valid = 4'b1111; #1;
    total++;
    if ({rdy0, rdy1} !== 8'h00) $display("FAIL reset_ready: got %b/%b want 0000/0000", rdy0, rdy1);
    else pass_cnt++;
    in_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_all_valid();
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_data(); #1;
      total++;
      if (rdy0 !== (4'(1) << (k % 4))) $display("FAIL rr_ready beat%0d: got %b want %b", k, rdy0, 4'(1) << (k % 4));
      else pass_cnt++;
      tick();
      total++;
      if ({ov0, och0, od0[31:24]} !== {1'b1, 2'(k % 4), 8'(8'hC0 + k % 4)})
        $display("FAIL rr_seq beat%0d: got v=%b ch=%0d tag=%h want v=1 ch=%0d tag=%h", k, ov0, och0, od0[31:24], k % 4, 8'(8'hC0 + k % 4));
      else pass_cnt++;
      for (int n = 0; n < 2; n++) begin
        total++;
        if ({o_v(n), o_ch(n), o_d(n)} !== {m_v[n], m_ch[n], m_d[n]})
          $display("FAIL all_valid_out inst%0d beat%0d: got v=%b ch=%0d d=%h want v=%b ch=%0d d=%h", n, k, o_v(n), o_ch(n), o_d(n), m_v[n], m_ch[n], m_d[n]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_alternate();
    logic [1:0] want;
    want = 2'd0;
    in_valid = 4'b0101; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_data(); #1;
      total++;
      if ({rdy0[3], rdy0[1]} !== 2'b00 || rdy0 !== exp_rdy(0))
        $display("FAIL alt_ready beat%0d: got %b want %b", k, rdy0, exp_rdy(0));
      else pass_cnt++;
      tick();
      total++;
      if ({ov0, och0, od0} !== {1'b1, want, m_d[0]})
        $display("FAIL alt_grant beat%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", k, ov0, och0, od0, want, m_d[0]);
      else pass_cnt++;
      want = (want == 2'd0) ? 2'd2 : 2'd0;
    end
  endtask

  task automatic test_backpressure();
    in_valid = '0; out_ready = 1'b1; tick();
    in_valid = 4'b0010; out_ready = 1'b0; set_data(); in_data[63:32] = 32'hA5; #1;
    tick();
    in_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      set_data(); #1;
      for (int n = 0; n < 2; n++) begin
        total++;
        if ({o_v(n), o_ch(n), o_d(n), o_rdy(n)} !== {1'b1, 2'd1, 32'hA5, 4'b0})
          $display("FAIL bp_hold inst%0d cyc%0d: got v=%b ch=%0d d=%h rdy=%b want v=1 ch=1 d=a5 rdy=0000", n, c, o_v(n), o_ch(n), o_d(n), o_rdy(n));
        else pass_cnt++;
      end
      tick();
    end
    out_ready = 1'b1; set_data(); #1;
    total++;
    if ({rdy0, rdy1} !== {4'b0100, 4'b0001}) $display("FAIL bp_release_ready: got %b/%b want 0100/0001", rdy0, rdy1);
    else pass_cnt++;
    tick();
    total++;
    if ({ov0, och0, od0, ov1, och1, od1} !== {1'b1, 2'd2, m_d[0], 1'b1, 2'd0, m_d[1]})
      $display("FAIL bp_reload: got ch=%0d/%0d d=%h/%h want ch=2/0 d=%h/%h", och0, och1, od0, od1, m_d[0], m_d[1]);
    else pass_cnt++;
  endtask

  task automatic test_fixed_prio();
    in_valid = 4'b0110; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_data(); #1;
      total++;
      if (rdy1 !== 4'b0010) $display("FAIL fp_ready beat%0d: got %b want 0010", k, rdy1);
      else pass_cnt++;
      tick();
      total++;
      if ({ov1, och1, od1[31:24]} !== {1'b1, 2'd1, 8'hC1})
        $display("FAIL fp_grant beat%0d: got v=%b ch=%0d tag=%h want v=1 ch=1 tag=c1", k, ov1, och1, od1[31:24]);
      else pass_cnt++;
    end
    in_valid = 4'b0100; set_data(); #1;
    tick();
    total++;
    if ({ov1, och1, od1} !== {1'b1, 2'd2, m_d[1]}) $display("FAIL fp_ch2: got ch=%0d d=%h want ch=2 d=%h", och1, od1, m_d[1]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      set_data(); #1;
      for (int n = 0; n < 2; n++) begin
        total++;
        if (o_rdy(n) !== exp_rdy(n))
          $display("FAIL rand_ready inst%0d cyc%0d: got %b want %b", n, c, o_rdy(n), exp_rdy(n));
        else pass_cnt++;
      end
      tick();
      for (int n = 0; n < 2; n++) begin
        total++;
        if ({o_v(n), o_ch(n), o_d(n)} !== {m_v[n], m_ch[n], m_d[n]})
          $display("FAIL rand_out inst%0d cyc%0d: got v=%b ch=%0d d=%h want v=%b ch=%0d d=%h", n, c, o_v(n), o_ch(n), o_d(n), m_v[n], m_ch[n], m_d[n]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_async_reset();
    in_valid = 4'b1111; out_ready = 1'b1; set_data(); #1;
    tick();
    total++;
    if ({ov0, ov1} !== 2'b11) $display("FAIL arst_pre: got v=%b/%b want 1/1", ov0, ov1);
    else pass_cnt++;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if ({ov0, ov1, od0, od1, och0, och1, rdy0, rdy1} !== '0)
      $display("FAIL arst_clear: got v=%b/%b d=%h/%h ch=%0d/%0d rdy=%b/%b want all 0", ov0, ov1, od0, od1, och0, och1, rdy0, rdy1);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    #1;
    total++;
    if ({rdy0, rdy1} !== {4'b0001, 4'b0001}) $display("FAIL arst_ready: got %b/%b want 0001/0001", rdy0, rdy1);
    else pass_cnt++;
    tick();
    total++;
    if ({ov0, och0, od0} !== {1'b1, 2'd0, m_d[0]}) $display("FAIL arst_first: got v=%b ch=%0d d=%h want v=1 ch=0 d=%h", ov0, och0, od0, m_d[0]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_alternate();
    test_backpressure();
    test_fixed_prio();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
